// File: rtl/atb_trace_funnel_pkg.sv
// Shared types for the ATB trace funnel and related trace arbiters.
// Beat records are sized for the widest supported sink (64-bit data).
package atb_trace_funnel_pkg;

  localparam int ATB_ID_W        = 7;
  localparam int ATB_DATA_MAX_W  = 64;
  localparam int ATB_BYTES_MAX_W = 3;

  typedef struct packed {
    logic [ATB_DATA_MAX_W-1:0]  data;
    logic [ATB_BYTES_MAX_W-1:0] bytes;
    logic [ATB_ID_W-1:0]        id;
  } atb_beat_t;

  typedef enum logic {
    IDLE,
    GRANT
  } funnel_state_e;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_DONE
  } flush_state_e;

endpackage

// File: rtl/atb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Returns a one-hot grant (all zero when no request) and its index.
module atb_rr_arbiter #(
  parameter int NSRC  = 2,
  parameter int IDX_W = $clog2(NSRC)
) (
  input  logic [NSRC-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NSRC-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic found;
  int   j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int off = 0; off < NSRC; off++) begin
      j = int'(ptr) + off;
      if (j >= NSRC) j = j - NSRC;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/atb_trace_funnel.sv
// Round-robin ATB funnel: NSRC trace sources into one registered sink slice,
// with bounded bursts per grant and flush fan-out/collection.
//
// state  | meaning
// IDLE   | no grant; arbitrate among valid, enabled sources (1-cycle bubble)
// GRANT  | grant_q owns the slice; up to HOLD_BEATS beats accepted
// F_IDLE | no flush in progress
// F_REQ  | flush fanned out to latched sources; waiting for acks and drain
// F_DONE | flush acknowledged; waiting for sink to drop AFVALID
module atb_trace_funnel
  import atb_trace_funnel_pkg::*;
#(
  parameter int NSRC       = 2,
  parameter int DATA_LEN   = 32,
  parameter int HOLD_BEATS = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NSRC-1:0]                     enable_i,
  input  logic [NSRC-1:0]                     s_atvalid_i,
  input  logic [NSRC*DATA_LEN-1:0]            s_atdata_i,
  input  logic [NSRC*($clog2(DATA_LEN)-3)-1:0] s_atbytes_i,
  input  logic [NSRC*7-1:0]                   s_atid_i,
  output logic [NSRC-1:0]                     s_atready_o,
  output logic [NSRC-1:0]                     s_afvalid_o,
  input  logic [NSRC-1:0]                     s_afready_i,
  output logic                                m_atvalid_o,
  output logic [DATA_LEN-1:0]                 m_atdata_o,
  output logic [$clog2(DATA_LEN)-3-1:0]       m_atbytes_o,
  output logic [6:0]                          m_atid_o,
  input  logic                                m_atready_i,
  input  logic                                m_afvalid_i,
  output logic                                m_afready_o,
  output logic [$clog2(NSRC)-1:0]             grant_o,
  output logic                                busy_o
);

  localparam int IDX_W   = $clog2(NSRC);
  localparam int BYTES_W = $clog2(DATA_LEN) - 3;
  localparam int CNT_W   = $clog2(HOLD_BEATS + 1);

  typedef struct packed {
    logic [DATA_LEN-1:0] data;
    logic [BYTES_W-1:0]  bytes;
    logic [ATB_ID_W-1:0] id;
  } beat_t;

  funnel_state_e    state_q, state_d;
  flush_state_e     fstate_q, fstate_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] arb_idx, next_ptr;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [NSRC-1:0]  req, arb_gnt;
  logic [NSRC-1:0]  pend_q, pend_d;
  logic             arb_any;
  logic             can_load;
  logic             sel_vld, sel_en;
  logic             accept;
  logic             slice_vld_q;
  beat_t            sel_beat, slice_q;

  assign req = s_atvalid_i & enable_i;

  atb_rr_arbiter #(
    .NSRC  (NSRC),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (req),
    .ptr     (rr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign arb_any = |arb_gnt;

  always_comb begin
    sel_vld  = 1'b0;
    sel_en   = 1'b0;
    sel_beat = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_vld        = s_atvalid_i[i];
        sel_en         = enable_i[i];
        sel_beat.data  = s_atdata_i[i*DATA_LEN +: DATA_LEN];
        sel_beat.bytes = s_atbytes_i[i*BYTES_W +: BYTES_W];
        sel_beat.id    = s_atid_i[i*ATB_ID_W +: ATB_ID_W];
      end
    end
  end

  assign can_load = !slice_vld_q || m_atready_i;
  assign accept   = (state_q == GRANT) && sel_en && sel_vld && can_load;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign next_ptr = (grant_q == IDX_W'(NSRC - 1)) ? '0 : grant_q + IDX_W'(1);

  always_comb begin
    s_atready_o = '0;
    for (int i = 0; i < NSRC; i++) begin
      s_atready_o[i] = (state_q == GRANT) && (grant_q == IDX_W'(i)) &&
                       enable_i[i] && can_load;
    end
  end

  // Arbiter FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A dropped enable or valid ends the burst without taking a beat.
        if (!sel_en || !sel_vld) begin
          state_d = IDLE;
          rr_d    = next_ptr;
        end else if (can_load) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(HOLD_BEATS)) begin
            state_d = IDLE;
            rr_d    = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slice_vld_q <= 1'b0;
      slice_q     <= '0;
    end else if (accept) begin
      slice_vld_q <= 1'b1;
      slice_q     <= sel_beat;
    end else if (m_atready_i) begin
      slice_vld_q <= 1'b0;
    end
  end

  // Flush FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fstate_q <= F_IDLE;
      pend_q   <= '0;
    end else begin
      fstate_q <= fstate_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    fstate_d    = fstate_q;
    pend_d      = pend_q;
    m_afready_o = 1'b0;
    s_afvalid_o = '0;
    case (fstate_q)
      F_IDLE: begin
        if (m_afvalid_i) begin
          pend_d   = enable_i;
          fstate_d = F_REQ;
        end
      end
      F_REQ: begin
        s_afvalid_o = pend_q;
        pend_d      = pend_q & ~s_afready_i & enable_i;
        if ((pend_q == '0) && !slice_vld_q && (state_q == IDLE)) begin
          m_afready_o = 1'b1;
          fstate_d    = F_DONE;
        end
      end
      F_DONE: begin
        if (!m_afvalid_i) fstate_d = F_IDLE;
      end
      default: fstate_d = F_IDLE;
    endcase
  end

  assign m_atvalid_o = slice_vld_q;
  assign m_atdata_o  = slice_q.data;
  assign m_atbytes_o = slice_q.bytes;
  assign m_atid_o    = slice_q.id;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q == GRANT) || slice_vld_q;

endmodule

// File: tb/tb_atb_trace_funnel.sv
// Directed bench for atb_trace_funnel (NSRC=2, DATA_LEN=32, HOLD_BEATS=4).
module tb_atb_trace_funnel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  enable_i;
  logic [1:0]  s_atvalid_i;
  logic [63:0] s_atdata_i;
  logic [3:0]  s_atbytes_i;
  logic [13:0] s_atid_i;
  logic [1:0]  s_atready_o;
  logic [1:0]  s_afvalid_o;
  logic [1:0]  s_afready_i;
  logic        m_atvalid_o;
  logic [31:0] m_atdata_o;
  logic [1:0]  m_atbytes_o;
  logic [6:0]  m_atid_o;
  logic        m_atready_i;
  logic        m_afvalid_i;
  logic        m_afready_o;
  logic [0:0]  grant_o;
  logic        busy_o;

  atb_trace_funnel #(.NSRC(2), .DATA_LEN(32), .HOLD_BEATS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable_i),
    .s_atvalid_i (s_atvalid_i),
    .s_atdata_i  (s_atdata_i),
    .s_atbytes_i (s_atbytes_i),
    .s_atid_i    (s_atid_i),
    .s_atready_o (s_atready_o),
    .s_afvalid_o (s_afvalid_o),
    .s_afready_i (s_afready_i),
    .m_atvalid_o (m_atvalid_o),
    .m_atdata_o  (m_atdata_o),
    .m_atbytes_o (m_atbytes_o),
    .m_atid_o    (m_atid_o),
    .m_atready_i (m_atready_i),
    .m_afvalid_i (m_afvalid_i),
    .m_afready_o (m_afready_o),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;

  // Per-source beat queues and per-cycle observations
  logic [31:0] qd [2][16];
  logic [6:0]  qid [2];
  logic [1:0]  qb [2];
  int          qlen [2];
  int          qptr [2];
  logic [1:0]  acc;
  logic        rx;
  logic [31:0] rx_data;
  logic [6:0]  rx_id;
  logic [1:0]  rx_bytes;

  task automatic load_src(input int s, input int n, input logic [31:0] base,
                          input logic [6:0] id, input logic [1:0] b);
    qlen[s] = n;
    qptr[s] = 0;
    qid[s]  = id;
    qb[s]   = b;
    for (int k = 0; k < 16; k++) qd[s][k] = base + k;
  endtask

  task automatic step(input logic rdy);
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      s_atvalid_i[s]          = (qptr[s] < qlen[s]);
      s_atdata_i[s*32 +: 32]  = qd[s][qptr[s] & 15];
      s_atid_i[s*7 +: 7]      = qid[s];
      s_atbytes_i[s*2 +: 2]   = qb[s];
    end
    m_atready_i = rdy;
    @(negedge clk);
    acc = s_atready_o & s_atvalid_i;
    for (int s = 0; s < 2; s++) if (acc[s]) qptr[s] = qptr[s] + 1;
    rx       = m_atvalid_o && m_atready_i;
    rx_data  = m_atdata_o;
    rx_id    = m_atid_o;
    rx_bytes = m_atbytes_o;
  endtask

  task automatic apply_reset;
    rst_n       = 1'b0;
    enable_i    = 2'b00;
    s_atvalid_i = 2'b00;
    s_atdata_i  = '0;
    s_atbytes_i = '0;
    s_atid_i    = '0;
    s_afready_i = 2'b00;
    m_atready_i = 1'b0;
    m_afvalid_i = 1'b0;
    for (int s = 0; s < 2; s++) load_src(s, 0, 32'h0, 7'h0, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    enable_i    = 2'b11;
    s_atvalid_i = 2'b11;
    s_atdata_i  = '1;
    s_atbytes_i = '1;
    s_atid_i    = '1;
    s_afready_i = 2'b00;
    m_atready_i = 1'b1;
    m_afvalid_i = 1'b0;
    #2;
    total++;
    if (m_atvalid_o !== 1'b0) begin bad++; $display("FAIL reset_m_atvalid got=%b exp=0", m_atvalid_o); end
    total++;
    if (s_atready_o !== 2'b00) begin bad++; $display("FAIL reset_s_atready got=%b exp=00", s_atready_o); end
    total++;
    if (s_afvalid_o !== 2'b00) begin bad++; $display("FAIL reset_s_afvalid got=%b exp=00", s_afvalid_o); end
    total++;
    if ({m_atdata_o, m_atbytes_o, m_atid_o} !== 41'h0) begin
      bad++; $display("FAIL reset_m_fields got=%h/%h/%h exp=0", m_atdata_o, m_atbytes_o, m_atid_o);
    end
    total++;
    if ({m_afready_o, grant_o, busy_o} !== 3'b000) begin
      bad++; $display("FAIL reset_misc got=%b%b%b exp=000", m_afready_o, grant_o, busy_o);
    end
    apply_reset();
  endtask

  task automatic test_single_source;
    int rxn;
    int rxc [8];
    apply_reset();
    enable_i = 2'b01;
    load_src(0, 6, 32'h1000_0000, 7'h11, 2'b11);
    rxn = 0;
    for (int c = 0; c < 40 && rxn < 6; c++) begin
      step(1'b1);
      if (rx) begin
        total++;
        if (rx_data !== 32'h1000_0000 + rxn || rx_id !== 7'h11 || rx_bytes !== 2'b11) begin
          bad++;
          $display("FAIL single_beat%0d got=%h/%h/%h exp=%h/11/3", rxn, rx_data, rx_id, rx_bytes,
                   32'h1000_0000 + rxn);
        end
        rxc[rxn] = c;
        rxn++;
      end
    end
    total++;
    if (rxn !== 6) begin bad++; $display("FAIL single_count got=%0d exp=6", rxn); end
    else begin
      for (int k = 1; k < 6; k++) begin
        total++;
        if (rxc[k] - rxc[k-1] !== ((k == 4) ? 2 : 1)) begin
          bad++;
          $display("FAIL single_gap%0d got=%0d exp=%0d", k, rxc[k] - rxc[k-1], (k == 4) ? 2 : 1);
        end
      end
    end
  endtask

  task automatic test_contention;
    int       rxn;
    logic [6:0]  exp_id;
    logic [31:0] exp_data;
    apply_reset();
    enable_i = 2'b11;
    load_src(0, 8, 32'h2000_0000, 7'h10, 2'b11);
    load_src(1, 8, 32'h2100_0000, 7'h20, 2'b10);
    rxn = 0;
    for (int c = 0; c < 100 && rxn < 16; c++) begin
      step(1'b1);
      if (rx) begin
        exp_id   = ((rxn / 4) % 2 == 0) ? 7'h10 : 7'h20;
        exp_data = ((rxn / 4) % 2 == 0) ? 32'h2000_0000 + (rxn / 8) * 4 + rxn % 4
                                        : 32'h2100_0000 + (rxn / 8) * 4 + rxn % 4;
        total++;
        if (rx_id !== exp_id || rx_data !== exp_data ||
            rx_bytes !== ((exp_id == 7'h10) ? 2'b11 : 2'b10)) begin
          bad++;
          $display("FAIL contention_beat%0d got=%h/%h/%h exp=%h/%h", rxn, rx_id, rx_data, rx_bytes,
                   exp_id, exp_data);
        end
        rxn++;
      end
    end
    total++;
    if (rxn !== 16) begin bad++; $display("FAIL contention_count got=%0d exp=16", rxn); end
  endtask

  task automatic test_back_to_back_backpressure;
    int          rxn;
    int          e0, e1;
    logic        hold;
    logic [31:0] held;
    apply_reset();
    enable_i = 2'b11;
    load_src(0, 10, 32'h3000_0000, 7'h10, 2'b11);
    load_src(1, 10, 32'h3100_0000, 7'h20, 2'b10);
    rxn = 0; e0 = 0; e1 = 0; hold = 1'b0; held = '0;
    for (int c = 0; c < 300 && rxn < 20; c++) begin
      step((c % 5) < 3);
      if (hold) begin
        total++;
        if (m_atvalid_o !== 1'b1 || m_atdata_o !== held) begin
          bad++;
          $display("FAIL bp_stable got=%b/%h exp=1/%h", m_atvalid_o, m_atdata_o, held);
        end
      end
      hold = m_atvalid_o && !m_atready_i;
      held = m_atdata_o;
      if (rx) begin
        total++;
        if (rx_id == 7'h10) begin
          if (rx_data !== 32'h3000_0000 + e0) begin
            bad++; $display("FAIL bp_src0 got=%h exp=%h", rx_data, 32'h3000_0000 + e0);
          end
          e0++;
        end else if (rx_id == 7'h20) begin
          if (rx_data !== 32'h3100_0000 + e1) begin
            bad++; $display("FAIL bp_src1 got=%h exp=%h", rx_data, 32'h3100_0000 + e1);
          end
          e1++;
        end else begin
          bad++; $display("FAIL bp_id got=%h exp=10/20", rx_id);
        end
        rxn++;
      end
    end
    total++;
    if (e0 !== 10 || e1 !== 10) begin bad++; $display("FAIL bp_count got=%0d/%0d exp=10/10", e0, e1); end
  endtask

  task automatic test_flush;
    int   rxn, pulses;
    logic acked;
    apply_reset();
    enable_i = 2'b11;
    load_src(1, 3, 32'h4000_0000, 7'h21, 2'b10);
    m_afvalid_i = 1'b1;
    step(1'b1);
    total++;
    if (s_afvalid_o !== 2'b11) begin bad++; $display("FAIL flush_fanout got=%b exp=11", s_afvalid_o); end
    s_afready_i = 2'b01;
    step(1'b1);
    s_afready_i = 2'b00;
    rxn = rx ? 1 : 0;
    total++;
    if (s_afvalid_o !== 2'b10) begin bad++; $display("FAIL flush_src0_ack got=%b exp=10", s_afvalid_o); end
    acked = 1'b0; pulses = 0;
    for (int c = 0; c < 25; c++) begin
      if (qptr[1] == 3 && !acked) begin s_afready_i = 2'b10; acked = 1'b1; end
      else s_afready_i = 2'b00;
      step(1'b1);
      if (rx) rxn++;
      if (m_afready_o) begin
        pulses++;
        total++;
        if (rxn !== 3 || m_atvalid_o !== 1'b0 || !acked) begin
          bad++;
          $display("FAIL flush_early got=rx%0d/v%b exp=rx3/v0", rxn, m_atvalid_o);
        end
        m_afvalid_i = 1'b0;
      end
    end
    total++;
    if (pulses !== 1) begin bad++; $display("FAIL flush_pulse got=%0d exp=1", pulses); end
    total++;
    if (s_afvalid_o !== 2'b00 || rxn !== 3) begin
      bad++; $display("FAIL flush_end got=%b/%0d exp=00/3", s_afvalid_o, rxn);
    end
  endtask

  task automatic test_disable;
    int   n0, n1;
    logic dropped, first0;
    apply_reset();
    enable_i = 2'b11;
    load_src(1, 8, 32'h5100_0000, 7'h22, 2'b10);
    n0 = 0; n1 = 0; dropped = 1'b0; first0 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step(1'b1);
      if (dropped) begin
        total++;
        if (acc[1] !== 1'b0 || s_atready_o[1] !== 1'b0) begin
          bad++; $display("FAIL disable_src1 got=acc%b/rdy%b exp=0/0", acc[1], s_atready_o[1]);
        end
      end
      if (acc[1]) n1++;
      if (acc[0]) begin
        if (first0) begin
          total++;
          if (grant_o !== 1'b0) begin bad++; $display("FAIL disable_grant got=%b exp=0", grant_o); end
          first0 = 1'b0;
        end
        n0++;
      end
      if (n1 == 2 && !dropped) begin
        enable_i = 2'b01;
        load_src(0, 3, 32'h5000_0000, 7'h12, 2'b11);
        dropped = 1'b1;
      end
    end
    total++;
    if (n0 !== 3 || n1 !== 2) begin bad++; $display("FAIL disable_count got=%0d/%0d exp=3/2", n0, n1); end
  endtask

  task automatic test_reset_mid_burst;
    logic got;
    apply_reset();
    enable_i = 2'b01;
    load_src(0, 6, 32'h6000_0000, 7'h13, 2'b11);
    for (int c = 0; c < 30 && qptr[0] < 5; c++) step(1'b1);
    step(1'b0);
    step(1'b0);
    total++;
    if (m_atvalid_o !== 1'b1 || m_atdata_o !== 32'h6000_0004 || busy_o !== 1'b1) begin
      bad++; $display("FAIL midrst_pre got=%b/%h/%b exp=1/60000004/1", m_atvalid_o, m_atdata_o, busy_o);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({m_atvalid_o, busy_o, s_atready_o, grant_o, m_afready_o} !== 6'b0 ||
        m_atdata_o !== 32'h0 || m_atid_o !== 7'h0) begin
      bad++;
      $display("FAIL midrst_outputs got=%b%b%b%b%b/%h/%h exp=0", m_atvalid_o, busy_o, s_atready_o,
               grant_o, m_afready_o, m_atdata_o, m_atid_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    enable_i = 2'b11;
    load_src(0, 2, 32'h7000_0000, 7'h14, 2'b11);
    load_src(1, 2, 32'h7100_0000, 7'h24, 2'b10);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      step(1'b1);
      if (rx) begin
        got = 1'b1;
        total++;
        if (rx_id !== 7'h14 || rx_data !== 32'h7000_0000) begin
          bad++; $display("FAIL midrst_first got=%h/%h exp=14/70000000", rx_id, rx_data);
        end
      end
    end
    total++;
    if (!got) begin bad++; $display("FAIL midrst_timeout got=0 exp=1"); end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_contention();
    test_back_to_back_backpressure();
    test_flush();
    test_disable();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
